// File: rtl/sram_ctrl.sv
// sram_ctrl: host-side controller for a 2K x 8 asynchronous CMOS SRAM.
// Turns single-cycle host read/write requests into sequenced, active-low
// SRE/SRG/SRW strobes and owns the bidirectional SRAM data bus.
// Every output, including the data-bus enable, comes from a register.
// Optional feature macro: SRAM_CTRL_VERIFY_EN adds a read-back check after
// every write and the verr output.
module sram_ctrl #(
    parameter int unsigned AW     = 11,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_CYC = 2,
    parameter int unsigned WR_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic [AW-1:0] Address,
    inout  logic [DW-1:0] Data,
    output logic          SRE,
    output logic          SRG,
    output logic          SRW
`ifdef SRAM_CTRL_VERIFY_EN
    ,
    output logic          verr
`endif
);

    localparam int unsigned CMAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int unsigned CW   = $clog2(CMAX) + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        RD_ACT   = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
`ifdef SRAM_CTRL_VERIFY_EN
        ,
        VFY      = 3'd5
`endif
    } state_t;

    state_t        state_q;
    logic          ready_q;
    logic          done_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] addr_q;
    logic          sre_q;
    logic          srg_q;
    logic          srw_q;
    logic          drive_q;
    logic [DW-1:0] dout_q;
    logic          we_q;
    logic [CW-1:0] cnt_q;
`ifdef SRAM_CTRL_VERIFY_EN
    logic          verr_q;
`endif

    // Access sequencer: outputs are registered so they reflect the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            sre_q   <= 1'b1;
            srg_q   <= 1'b1;
            srw_q   <= 1'b1;
            drive_q <= 1'b0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SRAM_CTRL_VERIFY_EN
            verr_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        dout_q  <= wdata;
                        // Write data goes onto the bus during SETUP, ahead of the SRW pulse.
                        drive_q <= we;
                        sre_q   <= 1'b0;
                        ready_q <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
                        verr_q  <= 1'b0;
`endif
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (we_q) begin
                        srw_q   <= 1'b0;
                        cnt_q   <= CW'(WR_CYC - 1);
                        state_q <= WR_PULSE;
                    end else begin
                        srg_q   <= 1'b0;
                        cnt_q   <= CW'(RD_CYC - 1);
                        state_q <= RD_ACT;
                    end
                end
                RD_ACT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        rdata_q <= Data;
                        srg_q   <= 1'b1;
                        sre_q   <= 1'b1;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WR_PULSE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        srw_q   <= 1'b1;
                        state_q <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    drive_q <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
                    // One turnaround clock with SRG high before the read-back starts,
                    // so the released bus never overlaps SRAM output drive.
                    cnt_q   <= CW'(RD_CYC);
                    state_q <= VFY;
`else
                    sre_q   <= 1'b1;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
`endif
                end
`ifdef SRAM_CTRL_VERIFY_EN
                VFY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                        srg_q <= 1'b0;
                    end else begin
                        verr_q  <= (Data != dout_q);
                        srg_q   <= 1'b1;
                        sre_q   <= 1'b1;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign Address = addr_q;
    assign SRE     = sre_q;
    assign SRG     = srg_q;
    assign SRW     = srw_q;
    assign Data    = drive_q ? dout_q : 'z;
`ifdef SRAM_CTRL_VERIFY_EN
    assign verr    = verr_q;
`endif

    // Bus-safety invariants.
    a_no_contention: assert property (@(posedge clk) disable iff (reset)
        !(!srg_q && drive_q));
    a_srw_srg_excl: assert property (@(posedge clk) disable iff (reset)
        !(!srw_q && !srg_q));
    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (!sre_q && $past(!sre_q)) |-> $stable(addr_q));

endmodule
